// File: rtl/input_conditioner.sv
// Board input conditioner: 2-flop synchronizer, counter debouncer, rise/fall pulses
// and auto-repeat press pulses for masked inputs.
module input_conditioner #(
  parameter int unsigned     N_IN         = 6,
  parameter int unsigned     DEBOUNCE_CYC = 250000,
  parameter int unsigned     REPEAT_DLY   = 12500000,
  parameter int unsigned     REPEAT_RATE  = 2500000,
  parameter logic [N_IN-1:0] REPEAT_MASK  = N_IN'(6'b000011)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_IN-1:0] D_raw,
  output logic [N_IN-1:0] D,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  output logic [N_IN-1:0] press
);

  localparam int unsigned DW      = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned HW      = $clog2(REP_MAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] DLY_LAST  = HW'(REPEAT_DLY - 1);
  localparam logic [HW-1:0] RATE_LAST = HW'(REPEAT_RATE - 1);

  typedef enum logic {
    PH_DLY,
    PH_RATE
  } phase_e;

  logic [N_IN-1:0] s1_q, s2_q;
  logic [N_IN-1:0] d_q, d_d;
  logic [N_IN-1:0] rise_q, rise_d;
  logic [N_IN-1:0] fall_q, fall_d;
  logic [N_IN-1:0] press_q, press_d;
  logic [DW-1:0]   db_q   [N_IN];
  logic [DW-1:0]   db_d   [N_IN];
  logic [HW-1:0]   hold_q [N_IN];
  logic [HW-1:0]   hold_d [N_IN];
  phase_e          phase_q[N_IN];
  phase_e          phase_d[N_IN];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q    <= '0;
      s2_q    <= '0;
      d_q     <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      press_q <= '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        db_q[i]    <= '0;
        hold_q[i]  <= '0;
        phase_q[i] <= PH_DLY;
      end
    end else begin
      s1_q    <= D_raw;
      s2_q    <= s1_q;
      d_q     <= d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    d_d     = d_q;
    db_d    = db_q;
    hold_d  = hold_q;
    phase_d = phase_q;
    press_d = '0;

    for (int unsigned i = 0; i < N_IN; i++) begin
      if (s2_q[i] == d_q[i]) begin
        db_d[i] = '0;
      end else if (db_q[i] == DB_LAST) begin
        d_d[i]  = s2_q[i];
        db_d[i] = '0;
      end else begin
        db_d[i] = db_q[i] + 1'b1;
      end
    end

    rise_d = d_d & ~d_q;
    fall_d = ~d_d & d_q;

    // Repeat decisions use the new level so the fall cycle can never carry a press.
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (!REPEAT_MASK[i]) begin
        press_d[i] = rise_d[i];
        hold_d[i]  = '0;
        phase_d[i] = PH_DLY;
      end else if (rise_d[i]) begin
        press_d[i] = 1'b1;
        hold_d[i]  = '0;
        phase_d[i] = PH_DLY;
      end else if (d_d[i]) begin
        unique case (phase_q[i])
          PH_DLY: begin
            if (hold_q[i] == DLY_LAST) begin
              press_d[i] = 1'b1;
              hold_d[i]  = '0;
              phase_d[i] = PH_RATE;
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
          end
          PH_RATE: begin
            if (hold_q[i] == RATE_LAST) begin
              press_d[i] = 1'b1;
              hold_d[i]  = '0;
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
          end
          default: begin
            hold_d[i]  = '0;
            phase_d[i] = PH_DLY;
          end
        endcase
      end else begin
        hold_d[i]  = '0;
        phase_d[i] = PH_DLY;
      end
    end
  end

  assign D     = d_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign press = press_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: directed scenarios followed by random
// input activity, checked against a window/arithmetic reference model.
module tb_input_conditioner;

  localparam int DC   = 4;
  localparam int DLY  = 10;
  localparam int RATE = 3;
  localparam logic [5:0] MASK = 6'b000011;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] D_raw;
  logic [5:0] D, rise, fall, press;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [5:0] d;
    logic [5:0] r;
    logic [5:0] f;
    logic [5:0] p;
  } exp_t;

  exp_t sb[$];

  input_conditioner #(
    .N_IN(6),
    .DEBOUNCE_CYC(DC),
    .REPEAT_DLY(DLY),
    .REPEAT_RATE(RATE),
    .REPEAT_MASK(MASK)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .D_raw(D_raw),
    .D(D),
    .rise(rise),
    .fall(fall),
    .press(press)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  // Reference model: the level is accepted once the last DC synchronized samples all
  // disagree with it; press times follow from the rise cycle by plain arithmetic.
  initial begin : model
    logic [5:0] s1m, s2m, dm, dn, rz, fl, pr;
    logic [5:0] hist[$];
    int         t;
    int         rcyc[6];
    int         dt;
    bit         flip;
    s1m = '0; s2m = '0; dm = '0; t = 0;
    for (int i = 0; i < 6; i++) rcyc[i] = 0;
    forever begin
      @(posedge CLK);
      if (RST) begin
        s1m = '0; s2m = '0; dm = '0; t = 0;
        hist.delete();
        for (int k = 0; k < DC; k++) hist.push_back(6'h00);
        for (int i = 0; i < 6; i++) rcyc[i] = 0;
        sb.push_back('0);
      end else begin
        t++;
        hist.push_back(s2m);
        while (hist.size() > DC) void'(hist.pop_front());
        dn = dm;
        for (int i = 0; i < 6; i++) begin
          flip = 1'b1;
          for (int k = 0; k < hist.size(); k++)
            if (hist[k][i] == dm[i]) flip = 1'b0;
          if (flip) dn[i] = ~dm[i];
        end
        rz = dn & ~dm;
        fl = ~dn & dm;
        pr = '0;
        for (int i = 0; i < 6; i++) begin
          if (rz[i]) begin
            rcyc[i] = t;
            pr[i]   = 1'b1;
          end else if (MASK[i] && dn[i]) begin
            dt = t - rcyc[i];
            if (dt == DLY || (dt > DLY && ((dt - DLY) % RATE) == 0)) pr[i] = 1'b1;
          end
        end
        dm  = dn;
        s2m = s1m;
        s1m = D_raw;
        sb.push_back({dn, rz, fl, pr});
      end
    end
  end

  // Monitor: while reset is asserted every output must read zero.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty t=%0t actual=0 entries expected>=1", $time);
      end else begin
        e = sb.pop_front();
        if (RST) e = '0;
        chk("D", D, e.d);
        chk("rise", rise, e.r);
        chk("fall", fall, e.f);
        chk("press", press, e.p);
        chk("rise_fall_excl", rise & fall, 6'h00);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  initial begin : stim
    int r, b, len;
    RST   = 1'b0;
    D_raw = '0;
    #1 RST = 1'b1;

    // Inputs held through reset release.
    D_raw = 6'h3F;
    cyc(3);
    RST = 1'b0;
    cyc(12);
    D_raw = '0;
    cyc(12);

    // Single clean rise on bit 2.
    D_raw[2] = 1'b1;
    cyc(10);
    D_raw[2] = 1'b0;
    cyc(10);

    // Glitch shorter than the debounce window.
    D_raw[3] = 1'b1;
    cyc(3);
    D_raw[3] = 1'b0;
    cyc(10);

    // Auto-repeat on masked bit 0, then release.
    D_raw[0] = 1'b1;
    cyc(40);
    D_raw[0] = 1'b0;
    cyc(10);

    // Unmasked bit 5 held.
    D_raw[5] = 1'b1;
    cyc(40);
    D_raw[5] = 1'b0;
    cyc(10);

    // Simultaneous rise on bits 1:0, reset mid-repeat, inputs held.
    D_raw[1:0] = 2'b11;
    cyc(12);
    RST = 1'b1;
    cyc(2);
    RST = 1'b0;
    cyc(20);
    D_raw = '0;
    cyc(10);

    // Random activity: level changes, glitches around the debounce length, resets.
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        RST = 1'b1;
        cyc(int'($urandom_range(1, 2)));
        RST = 1'b0;
        cyc(1);
      end else if (r < 7) begin
        b   = int'($urandom_range(0, 5));
        len = int'($urandom_range(1, DC + 1));
        D_raw[b] = ~D_raw[b];
        cyc(len);
        D_raw[b] = ~D_raw[b];
        cyc(int'($urandom_range(1, 8)));
      end else begin
        D_raw = D_raw ^ 6'($urandom_range(1, 63));
        cyc(int'($urandom_range(1, 30)));
      end
    end

    D_raw = '0;
    cyc(12);
    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
